// File: rtl/axi_read_burst_issuer_if.sv
// AR-channel bundle between the burst issuer and the AXI4 read address port.
// Ports / signals:
//   arvalid  burst request valid (driven by the issuer)
//   arready  slave ready (driven by the interconnect)
//   araddr   burst byte address
//   arlen    burst length minus one
// Modports: master (issuer side), slave (interconnect side).
interface axi_read_burst_issuer_if #(
   parameter int C_ADDR_WIDTH = 64
) ();
   logic                    arvalid;
   logic                    arready;
   logic [C_ADDR_WIDTH-1:0] araddr;
   logic [7:0]              arlen;

   modport master (
      output arvalid,
      output araddr,
      output arlen,
      input  arready
   );

   modport slave (
      input  arvalid,
      input  araddr,
      input  arlen,
      output arready
   );
endinterface

// File: rtl/axi_read_burst_issuer.sv
// Splits one read request (byte address + beat count) into AXI4 AR bursts that
// never cross a 4 KiB boundary, while bounding the number of bursts in flight.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ctrl_start/addr/length  request pulse, byte address, length in beats
//   ctrl_busy, ctrl_done    request in progress, one-cycle completion pulse
//   m_axi                   AR channel (master modport)
//   r_burst_done            one pulse per completed burst from the R path
//   outstanding             bursts issued but not completed
//   err_underflow           sticky: completion seen with nothing outstanding
module axi_read_burst_issuer #(
   parameter int C_ADDR_WIDTH      = 64,
   parameter int C_DATA_WIDTH      = 512,
   parameter int C_LENGTH_WIDTH    = 32,
   parameter int C_BURST_LEN       = 64,
   parameter int C_MAX_OUTSTANDING = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ctrl_start,
   input  logic [C_ADDR_WIDTH-1:0]   ctrl_addr,
   input  logic [C_LENGTH_WIDTH-1:0] ctrl_length,
   output logic                      ctrl_busy,
   output logic                      ctrl_done,
   axi_read_burst_issuer_if.master   m_axi,
   input  logic                      r_burst_done,
   output logic [7:0]                outstanding,
   output logic                      err_underflow
);

   localparam int BYTES     = C_DATA_WIDTH / 8;
   localparam int LOG_BYTES = $clog2(BYTES);
   // Common width for comparing the remaining count against the burst cap.
   localparam int CMP_W     = (C_LENGTH_WIDTH > 13) ? C_LENGTH_WIDTH : 13;
   localparam logic [C_ADDR_WIDTH-1:0] ALIGN_MASK = ~C_ADDR_WIDTH'(BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Beats of the next burst: min(remaining, C_BURST_LEN, beats left in 4 KiB page).
   // The address is always beat aligned, so the page division is exact.
   function automatic logic [8:0] burst_size(input logic [C_ADDR_WIDTH-1:0]   addr,
                                             input logic [C_LENGTH_WIDTH-1:0] rem);
      logic [12:0] to_4k;
      logic [12:0] cap;
      to_4k = (13'h1000 - {1'b0, addr[11:0]}) >> LOG_BYTES;
      cap   = (to_4k < 13'(C_BURST_LEN)) ? to_4k : 13'(C_BURST_LEN);
      if (CMP_W'(rem) < CMP_W'(cap)) begin
         burst_size = 9'(rem);
      end else begin
         burst_size = 9'(cap);
      end
   endfunction

   state_t                    state_r, state_nx_s;
   logic                      arvalid_r, arvalid_nx_s;
   logic [C_ADDR_WIDTH-1:0]   araddr_r, araddr_nx_s;
   logic [7:0]                arlen_r, arlen_nx_s;
   logic [C_LENGTH_WIDTH-1:0] rem_r, rem_nx_s;
   logic                      busy_r, busy_nx_s;
   logic                      done_r, done_nx_s;
   logic [7:0]                outstanding_r, outstanding_nx_s;
   logic                      err_r, err_nx_s;

   logic                      hs_s;
   logic [8:0]                cur_size_s;
   logic [C_ADDR_WIDTH-1:0]   next_addr_s;
   logic [C_LENGTH_WIDTH-1:0] next_rem_s;
   logic [C_ADDR_WIDTH-1:0]   calc_addr_s;
   logic [C_LENGTH_WIDTH-1:0] calc_rem_s;
   logic [8:0]                calc_size_s;
   logic                      below_limit_s;

   assign hs_s        = arvalid_r & m_axi.arready;
   assign cur_size_s  = {1'b0, arlen_r} + 9'd1;
   assign next_addr_s = araddr_r + (C_ADDR_WIDTH'(cur_size_s) << LOG_BYTES);
   assign next_rem_s  = rem_r - C_LENGTH_WIDTH'(cur_size_s);
   // Compared against the post-update count so arvalid drops the cycle the limit is reached.
   assign below_limit_s = (9'(outstanding_nx_s) < 9'(C_MAX_OUTSTANDING));

   // Burst calculator input: the new request in IDLE, otherwise the post-handshake position.
   always_comb begin
      calc_addr_s = next_addr_s;
      calc_rem_s  = next_rem_s;
      if (state_r == ST_IDLE) begin
         calc_addr_s = ctrl_addr & ALIGN_MASK;
         calc_rem_s  = ctrl_length;
      end else begin
         calc_addr_s = next_addr_s;
         calc_rem_s  = next_rem_s;
      end
      calc_size_s = burst_size(calc_addr_s, calc_rem_s);
   end

   // Outstanding-burst counter and sticky underflow flag; simultaneous events cancel.
   always_comb begin
      outstanding_nx_s = outstanding_r;
      err_nx_s         = err_r;
      if (hs_s && !r_burst_done) begin
         outstanding_nx_s = outstanding_r + 8'd1;
      end else if (!hs_s && r_burst_done) begin
         if (outstanding_r == 8'd0) begin
            err_nx_s = 1'b1;
         end else begin
            outstanding_nx_s = outstanding_r - 8'd1;
         end
      end else begin
         outstanding_nx_s = outstanding_r;
      end
   end

   // Request FSM next-state and next values of the registered outputs.
   always_comb begin
      state_nx_s   = state_r;
      arvalid_nx_s = arvalid_r;
      araddr_nx_s  = araddr_r;
      arlen_nx_s   = arlen_r;
      rem_nx_s     = rem_r;
      busy_nx_s    = busy_r;
      done_nx_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy_nx_s = 1'b0;
            if (ctrl_start) begin
               busy_nx_s = 1'b1;
               if (ctrl_length != {C_LENGTH_WIDTH{1'b0}}) begin
                  state_nx_s   = ST_ISSUE;
                  araddr_nx_s  = calc_addr_s;
                  arlen_nx_s   = 8'(calc_size_s - 9'd1);
                  rem_nx_s     = ctrl_length;
                  arvalid_nx_s = below_limit_s;
               end else begin
                  // Zero-length request: busy and done together for one cycle.
                  state_nx_s = ST_DONE;
                  done_nx_s  = 1'b1;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (hs_s) begin
               rem_nx_s = next_rem_s;
               if (next_rem_s == {C_LENGTH_WIDTH{1'b0}}) begin
                  state_nx_s   = ST_DRAIN;
                  arvalid_nx_s = 1'b0;
               end else begin
                  araddr_nx_s  = calc_addr_s;
                  arlen_nx_s   = 8'(calc_size_s - 9'd1);
                  arvalid_nx_s = below_limit_s;
               end
            end else if (arvalid_r) begin
               // A presented burst stays presented until accepted.
               arvalid_nx_s = 1'b1;
            end else begin
               arvalid_nx_s = below_limit_s;
            end
         end
         ST_DRAIN: begin
            if (outstanding_r == 8'd0) begin
               state_nx_s = ST_DONE;
               busy_nx_s  = 1'b0;
               done_nx_s  = 1'b1;
            end else begin
               state_nx_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
            busy_nx_s  = 1'b0;
         end
         default: begin
            state_nx_s   = ST_IDLE;
            arvalid_nx_s = 1'b0;
            busy_nx_s    = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         arvalid_r     <= 1'b0;
         araddr_r      <= {C_ADDR_WIDTH{1'b0}};
         arlen_r       <= 8'd0;
         rem_r         <= {C_LENGTH_WIDTH{1'b0}};
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         outstanding_r <= 8'd0;
         err_r         <= 1'b0;
      end else begin
         state_r       <= state_nx_s;
         arvalid_r     <= arvalid_nx_s;
         araddr_r      <= araddr_nx_s;
         arlen_r       <= arlen_nx_s;
         rem_r         <= rem_nx_s;
         busy_r        <= busy_nx_s;
         done_r        <= done_nx_s;
         outstanding_r <= outstanding_nx_s;
         err_r         <= err_nx_s;
      end
   end

   assign m_axi.arvalid = arvalid_r;
   assign m_axi.araddr  = araddr_r;
   assign m_axi.arlen   = arlen_r;
   assign ctrl_busy     = busy_r;
   assign ctrl_done     = done_r;
   assign outstanding   = outstanding_r;
   assign err_underflow = err_r;

endmodule
